// File: rtl/adc_serial_capture.sv
// Serial ADC capture front end: frames cs_n/adclk for a 12-bit serial ADC,
// deserialises ad_in, rejects frames with a set null bit and sums groups of
// 2^AVG_LOG2 good samples into volt.
module adc_serial_capture #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned LEAD_BITS  = 3,
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned GAP_CYC    = 32,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 ad_in,
  output logic                 adclk,
  output logic                 cs_n,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_vld,
  output logic                 frame_err,
  output logic [15:0]          volt,
  output logic                 volt_vld
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned SumW = DATA_BITS + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;

  localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] NullIdx   = BitW'(LEAD_BITS - 1);
  localparam logic [BitW-1:0] DataFirst = BitW'(LEAD_BITS);
  localparam logic [BitW-1:0] DataLast  = BitW'(LEAD_BITS + DATA_BITS - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(FRAME_BITS - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'(GAP_CYC - 1);
  localparam logic [CntW-1:0] AccLast   = CntW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StDone, StGap} state_e;

  state_e               state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic                 adclk_q, adclk_d;
  logic [1:0]           sync_q, sync_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 null_q, null_d;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 sample_vld_q, sample_vld_d;
  logic                 frame_err_q, frame_err_d;
  logic [SumW-1:0]      acc_q, acc_d;
  logic [CntW-1:0]      acc_n_q, acc_n_d;
  logic [15:0]          volt_q, volt_d;
  logic                 volt_vld_q, volt_vld_d;
  logic [SumW-1:0]      sum;

  // Next-state: framing FSM, bit capture, good-sample accumulation
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    adclk_d      = adclk_q;
    sync_d       = {sync_q[0], ad_in};
    shift_d      = shift_q;
    null_d       = null_q;
    sample_d     = sample_q;
    sample_vld_d = 1'b0;
    frame_err_d  = 1'b0;
    acc_d        = acc_q;
    acc_n_d      = acc_n_q;
    volt_d       = volt_q;
    volt_vld_d   = 1'b0;
    sum          = acc_q + SumW'(shift_q);

    unique case (state_q)
      StIdle: begin
        div_d = '0;
        if (en) state_d = StSetup;
      end
      StSetup: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          adclk_d = ~adclk_q;
          // adclk high here means this is the falling edge: take one bit
          if (adclk_q) begin
            if (bit_q == NullIdx) begin
              null_d = sync_q[1];
            end else if (bit_q >= DataFirst && bit_q <= DataLast) begin
              shift_d = {shift_q[DATA_BITS-2:0], sync_q[1]};
            end
            if (bit_q == BitLast) state_d = StDone;
            else                  bit_d   = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        gap_d   = '0;
        state_d = StGap;
        if (!null_q) begin
          sample_d     = shift_q;
          sample_vld_d = 1'b1;
          if (acc_n_q == AccLast) begin
            volt_d     = 16'(sum);
            volt_vld_d = 1'b1;
            acc_d      = '0;
            acc_n_d    = '0;
          end else begin
            acc_d   = sum;
            acc_n_d = acc_n_q + 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          div_d   = '0;
          state_d = en ? StSetup : StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      div_q        <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      adclk_q      <= 1'b0;
      sync_q       <= '0;
      shift_q      <= '0;
      null_q       <= 1'b0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      frame_err_q  <= 1'b0;
      acc_q        <= '0;
      acc_n_q      <= '0;
      volt_q       <= '0;
      volt_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      adclk_q      <= adclk_d;
      sync_q       <= sync_d;
      shift_q      <= shift_d;
      null_q       <= null_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      frame_err_q  <= frame_err_d;
      acc_q        <= acc_d;
      acc_n_q      <= acc_n_d;
      volt_q       <= volt_d;
      volt_vld_q   <= volt_vld_d;
    end
  end

  assign cs_n       = !(state_q == StSetup || state_q == StShift);
  assign adclk      = adclk_q;
  assign sample     = sample_q;
  assign sample_vld = sample_vld_q;
  assign frame_err  = frame_err_q;
  assign volt       = volt_q;
  assign volt_vld   = volt_vld_q;

endmodule
